// File: rtl/clock_set_ctrl_if.sv
// Interface bundling the raw button inputs and the time/display outputs of
// the clock set controller. The controller uses the slave view; the board
// or bench side uses the master view.
interface clock_set_ctrl_if;
    logic       btn_mode;   // raw MODE button, asynchronous, active-high
    logic       btn_inc;    // raw INC button, asynchronous, active-high
    logic [4:0] hours;      // 0..23
    logic [5:0] minutes;    // 0..59
    logic [5:0] seconds;    // 0..59
    logic [1:0] set_mode;   // 00 RUN, 01 SET_HOUR, 10 SET_MIN, 11 SET_SEC
    logic       sec_tick;   // one-cycle pulse per elapsed second
    logic [2:0] blank;      // {hours, minutes, seconds} blank request

    // Controller view: samples buttons, drives time and display fields.
    modport slave (
        input  btn_mode,
        input  btn_inc,
        output hours,
        output minutes,
        output seconds,
        output set_mode,
        output sec_tick,
        output blank
    );

    // Board / bench view: drives buttons, observes the controller.
    modport master (
        output btn_mode,
        output btn_inc,
        input  hours,
        input  minutes,
        input  seconds,
        input  set_mode,
        input  sec_tick,
        input  blank
    );
endinterface

// File: rtl/clock_set_ctrl.sv
// Timekeeping and time-set controller for the TT digital clock.
//  - Divides clk down to a one-cycle-per-second tick and keeps HH:MM:SS (24 h).
//  - Two debounced buttons (MODE, INC) walk a set-mode FSM that edits hours
//    and minutes and clears seconds.
//  - All time, mode and display outputs come straight from registers.
// Optional feature macro: CLOCK_SET_BLINK_EN
//  - defined:   the field under edit blinks through the blank outputs.
//  - undefined: blank is tied to 3'b000 and no blink logic exists.
module clock_set_ctrl #(
    parameter int TICK_DIV   = 65536,  // clk cycles per second tick (>= 2)
    parameter int DEB_CYCLES = 1024,   // stable cycles before a button level is accepted (>= 1)
    parameter int BLINK_DIV  = 32768   // clk cycles per blink phase toggle
) (
    input  logic            clk,
    input  logic            rst_n,
    clock_set_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10,
        SET_SEC  = 2'b11
    } state_e;

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    // Reject parameter values the counters below cannot honour.
    if (TICK_DIV < 2 || DEB_CYCLES < 1 || BLINK_DIV < 1) begin : g_param_check
        $error("clock_set_ctrl: TICK_DIV must be >= 2, DEB_CYCLES and BLINK_DIV >= 1");
    end

    // MODE step order; SET_SEC returns to RUN.
    function automatic state_e next_state(input state_e s);
        case (s)
            RUN:      return SET_HOUR;
            SET_HOUR: return SET_MIN;
            SET_MIN:  return SET_SEC;
            default:  return RUN;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Button conditioning. Bit 0 is MODE, bit 1 is INC.
    // ------------------------------------------------------------------
    logic [1:0]            btn_raw;
    logic [1:0]            sync1_q;
    logic [1:0]            sync2_q;
    logic [1:0]            lvl_q;
    logic [1:0]            lvl_d;
    logic [1:0]            lvl_prev_q;
    logic [1:0][DEB_W-1:0] deb_cnt_q;
    logic [1:0][DEB_W-1:0] deb_cnt_d;
    logic                  mode_p;
    logic                  inc_p;

    assign btn_raw = {bus.btn_inc, bus.btn_mode};

    // Debounce: the accepted level follows the synced level only after it has
    // differed for DEB_CYCLES consecutive cycles; any return resets the run.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        lvl_d     = lvl_q;
        deb_cnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != lvl_q[i]) begin
                if (deb_cnt_q[i] == DEB_W'(DEB_CYCLES - 1)) begin
                    lvl_d[i] = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Synchronizer flops, debounce counters and accepted/previous levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            lvl_q      <= '0;
            lvl_prev_q <= '0;
            deb_cnt_q  <= '0;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every
            // flop samples the pre-edge value of its neighbours.
            sync1_q    <= btn_raw;
            sync2_q    <= sync1_q;
            lvl_q      <= lvl_d;
            lvl_prev_q <= lvl_q;
            deb_cnt_q  <= deb_cnt_d;
        end
    end

    // One-cycle press pulses on the rising edge of the accepted level.
    assign mode_p = lvl_q[0] & ~lvl_prev_q[0];
    assign inc_p  = lvl_q[1] & ~lvl_prev_q[1];

    // ------------------------------------------------------------------
    // Set-mode FSM, prescaler and time fields.
    // ------------------------------------------------------------------
    state_e            state_q;
    logic [TICK_W-1:0] presc_q;
    logic [4:0]        hours_q;
    logic [5:0]        minutes_q;
    logic [5:0]        seconds_q;
    logic              sec_tick_q;
    logic              tick_due;

    assign tick_due = (presc_q == TICK_W'(TICK_DIV - 1));

    // FSM, prescaler and HH:MM:SS advance together. Ticks only happen in
    // RUN and INC is ignored in RUN, so the two never touch a field in the
    // same cycle; MODE takes priority over a coincident INC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            presc_q    <= '0;
            hours_q    <= '0;
            minutes_q  <= '0;
            seconds_q  <= '0;
            sec_tick_q <= 1'b0;
        end else begin
            sec_tick_q <= 1'b0;

            if (state_q == RUN) begin
                if (tick_due) begin
                    presc_q    <= '0;
                    sec_tick_q <= 1'b1;
                    if (seconds_q == 6'd59) begin
                        seconds_q <= '0;
                        if (minutes_q == 6'd59) begin
                            minutes_q <= '0;
                            hours_q   <= (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
                        end else begin
                            minutes_q <= minutes_q + 6'd1;
                        end
                    end else begin
                        seconds_q <= seconds_q + 6'd1;
                    end
                end else begin
                    presc_q <= presc_q + 1'b1;
                end
            end else begin
                // Held at zero so the first second after leaving set mode is full length.
                presc_q <= '0;
            end

            if (mode_p) begin
                state_q <= next_state(state_q);
            end else if (inc_p) begin
                case (state_q)
                    SET_HOUR: hours_q   <= (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
                    SET_MIN:  minutes_q <= (minutes_q == 6'd59) ? 6'd0 : minutes_q + 6'd1;
                    SET_SEC:  seconds_q <= '0;
                    default:  ;
                endcase
            end
        end
    end

    assign bus.hours    = hours_q;
    assign bus.minutes  = minutes_q;
    assign bus.seconds  = seconds_q;
    assign bus.set_mode = state_q;
    assign bus.sec_tick = sec_tick_q;

    // ------------------------------------------------------------------
    // Blink of the field under edit.
    // ------------------------------------------------------------------
`ifdef CLOCK_SET_BLINK_EN
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    state_e             state_nx;
    logic [BLINK_W-1:0] blink_cnt_q;
    logic [BLINK_W-1:0] blink_cnt_d;
    logic               phase_q;
    logic               phase_d;
    logic [2:0]         blank_q;
    logic [2:0]         blank_d;

    assign state_nx = mode_p ? next_state(state_q) : state_q;

    // Phase runs only while staying in a set state without an accepted INC;
    // entering a set state, an INC, or being in RUN restarts it visible.
    always_comb begin
        blink_cnt_d = '0;
        phase_d     = 1'b0;
        if (state_nx != RUN && state_nx == state_q && !inc_p) begin
            if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
                phase_d = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
                phase_d     = phase_q;
            end
        end
        case (state_nx)
            SET_HOUR: blank_d = {phase_d, 2'b00};
            SET_MIN:  blank_d = {1'b0, phase_d, 1'b0};
            SET_SEC:  blank_d = {2'b00, phase_d};
            default:  blank_d = 3'b000;
        endcase
    end

    // Blink counter, phase and the registered blank request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            blank_q     <= 3'b000;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            blank_q     <= blank_d;
        end
    end

    assign bus.blank = blank_q;
`else
    assign bus.blank = 3'b000;
`endif

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl. Time is modelled as a plain count
// of seconds since midnight; button presses are applied to that model with
// the field-edit rules, and second ticks are checked for exact cadence.
module tb_clock_set_ctrl;

    localparam int TICK_DIV   = 4;
    localparam int DEB_CYCLES = 2;
    localparam int BLINK_DIV  = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_time     = 0;   // seconds since midnight, 0..86399
    int m_mode     = 0;   // 0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 SET_SEC
    int ticks_used = 0;   // observed ticks already folded into m_time

    // Per-cycle observer state
    int         tick_seen = 0;
    int         run_age   = 0;
    logic [1:0] prev_mode = 2'b00;

    clock_set_ctrl_if bus ();

    clock_set_ctrl #(
        .TICK_DIV  (TICK_DIV),
        .DEB_CYCLES(DEB_CYCLES),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // ---------------- model helpers ----------------
    function automatic logic [18:0] exp_fields();
        return {5'(m_time / 3600), 6'((m_time / 60) % 60), 6'(m_time % 60), 2'(m_mode)};
    endfunction

    function automatic logic [18:0] dut_fields();
        return {bus.hours, bus.minutes, bus.seconds, bus.set_mode};
    endfunction

    function automatic string fmt(input logic [18:0] f);
        return $sformatf("%0d:%0d:%0d mode=%0d", f[18:14], f[13:8], f[7:2], f[1:0]);
    endfunction

    function automatic int rand_hold();
        return int'($urandom_range(DEB_CYCLES + 3, DEB_CYCLES));
    endfunction

    task automatic sync_model();
        while (ticks_used < tick_seen) begin
            m_time = (m_time + 1) % 86400;
            ticks_used++;
        end
    endtask

    task automatic apply_press(input bit do_mode, input bit do_inc);
        int h;
        int m;
        sync_model();
        h = m_time / 3600;
        m = (m_time / 60) % 60;
        if (do_mode) begin
            m_mode = (m_mode + 1) % 4;
        end else if (do_inc) begin
            case (m_mode)
                1: m_time = ((h + 1) % 24) * 3600 + (m_time % 3600);
                2: m_time = m_time - m * 60 + ((m + 1) % 60) * 60;
                3: m_time = m_time - (m_time % 60);
                default: ;
            endcase
        end
    endtask

    // Per-cycle observation at the falling edge: tick cadence, no ticks in
    // set states, and blank only on the field under edit.
    task automatic observe();
        logic [2:0] bad;
`ifdef CLOCK_SET_BLINK_EN
        logic [2:0] mask;
`endif
        logic exp_tick;
        if (!rst_n) begin
            run_age   = 0;
            prev_mode = 2'b00;
            tick_seen = 0;
            return;
        end
        if (bus.set_mode == 2'b00) begin
            run_age  = (prev_mode == 2'b00) ? run_age + 1 : 0;
            exp_tick = (run_age != 0) && (run_age % TICK_DIV == 0);
            n_checks++;
            if (bus.sec_tick !== exp_tick) begin
                n_fail++;
                $display("FAIL tick_cadence: sec_tick=%b want %b (cycle %0d in RUN)", bus.sec_tick, exp_tick, run_age);
            end
        end else if (prev_mode != 2'b00) begin
            n_checks++;
            if (bus.sec_tick !== 1'b0) begin
                n_fail++;
                $display("FAIL tick_in_set: sec_tick=%b want 0 in mode %0d", bus.sec_tick, bus.set_mode);
            end
        end
        if (bus.sec_tick === 1'b1) tick_seen++;
`ifdef CLOCK_SET_BLINK_EN
        case (bus.set_mode)
            2'b01:   mask = 3'b100;
            2'b10:   mask = 3'b010;
            2'b11:   mask = 3'b001;
            default: mask = 3'b000;
        endcase
        bad = bus.blank & ~mask;
`else
        bad = bus.blank;
`endif
        n_checks++;
        if (bad !== 3'b000) begin
            n_fail++;
            $display("FAIL blank_field: blank=%b in mode %0d", bus.blank, bus.set_mode);
        end
        prev_mode = bus.set_mode;
    endtask

    task automatic cyc();
        @(negedge clk);
        observe();
        #1;
    endtask

    task automatic press(input bit do_mode, input bit do_inc, input int hold);
        int gap;
        gap = int'($urandom_range(DEB_CYCLES + 4, DEB_CYCLES + 2));
        bus.btn_mode = do_mode;
        bus.btn_inc  = do_inc;
        repeat (hold) cyc();
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        repeat (gap) cyc();
        apply_press(do_mode, do_inc);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n        = 1'b0;
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        repeat (3) cyc();
        n_checks++;
        if ({dut_fields(), bus.sec_tick, bus.blank} !== 23'd0) begin
            n_fail++;
            $display("FAIL reset_state: %s tick=%b blank=%b, want all zero", fmt(dut_fields()), bus.sec_tick, bus.blank);
        end
        m_time = 0; m_mode = 0; ticks_used = 0;
        rst_n = 1'b1;
    endtask

    task automatic test_free_run();
        repeat (240) cyc();
        n_checks++;
        if (tick_seen != 60) begin
            n_fail++;
            $display("FAIL free_run_ticks: got %0d ticks, want 60", tick_seen);
        end
        n_checks++;
        if (dut_fields() !== {5'd0, 6'd1, 6'd0, 2'd0}) begin
            n_fail++;
            $display("FAIL free_run_time: got %s, want 0:1:0 mode=0", fmt(dut_fields()));
        end
        sync_model();
    endtask

    task automatic test_set_rollover();
        int n;
        int budget;
        press(1'b1, 1'b0, rand_hold());
        n = (23 - m_time / 3600 + 24) % 24;
        repeat (n) press(1'b0, 1'b1, rand_hold());
        press(1'b1, 1'b0, rand_hold());
        n = (59 - (m_time / 60) % 60 + 60) % 60;
        repeat (n) press(1'b0, 1'b1, rand_hold());
        press(1'b1, 1'b0, rand_hold());
        press(1'b0, 1'b1, rand_hold());
        n_checks++;
        if (dut_fields() !== {5'd23, 6'd59, 6'd0, 2'd3}) begin
            n_fail++;
            $display("FAIL set_2359: got %s, want 23:59:0 mode=3", fmt(dut_fields()));
        end
        press(1'b1, 1'b0, rand_hold());
        n_checks++;
        if (dut_fields() !== exp_fields()) begin
            n_fail++;
            $display("FAIL back_to_run: got %s, want %s", fmt(dut_fields()), fmt(exp_fields()));
        end
        for (budget = 0; budget < 400 && m_time != 0; budget++) begin
            cyc();
            sync_model();
            n_checks++;
            if (dut_fields() !== exp_fields()) begin
                n_fail++;
                $display("FAIL rollover_step: got %s, want %s", fmt(dut_fields()), fmt(exp_fields()));
            end
        end
        n_checks++;
        if (m_time != 0 || dut_fields() !== 19'd0 || bus.sec_tick !== 1'b1) begin
            n_fail++;
            $display("FAIL rollover_midnight: got %s tick=%b, want 0:0:0 mode=0 tick=1", fmt(dut_fields()), bus.sec_tick);
        end
    endtask

    task automatic test_hour_wrap();
        int n;
        logic [18:0] snap;
        press(1'b1, 1'b0, rand_hold());
        n = (5 - m_time / 3600 + 24) % 24;
        repeat (n) press(1'b0, 1'b1, rand_hold());
        snap = exp_fields();
        for (int i = 0; i < 24; i++) begin
            press(1'b0, 1'b1, rand_hold());
            n_checks++;
            if (dut_fields() !== exp_fields()) begin
                n_fail++;
                $display("FAIL hour_inc %0d: got %s, want %s", i, fmt(dut_fields()), fmt(exp_fields()));
            end
        end
        n_checks++;
        if (dut_fields() !== snap || bus.hours !== 5'd5) begin
            n_fail++;
            $display("FAIL hour_wrap24: got %s, want %s with hours=5", fmt(dut_fields()), fmt(snap));
        end
    endtask

    task automatic test_simultaneous();
        press(1'b1, 1'b1, rand_hold());
        n_checks++;
        if (dut_fields() !== exp_fields() || bus.set_mode !== 2'b10 || bus.hours !== 5'd5) begin
            n_fail++;
            $display("FAIL mode_beats_inc: got %s, want %s", fmt(dut_fields()), fmt(exp_fields()));
        end
    endtask

    task automatic test_glitch();
        logic [18:0] snap;
        snap = exp_fields();
        bus.btn_inc = 1'b1;
        repeat ($urandom_range(DEB_CYCLES - 1, 1)) cyc();
        bus.btn_inc = 1'b0;
        repeat (8) cyc();
        n_checks++;
        if (dut_fields() !== snap) begin
            n_fail++;
            $display("FAIL inc_glitch: got %s, want %s", fmt(dut_fields()), fmt(snap));
        end
        press(1'b0, 1'b1, 3);
        n_checks++;
        if (dut_fields() !== exp_fields() || bus.minutes === snap[13:8]) begin
            n_fail++;
            $display("FAIL inc_3cycle: got %s, want %s", fmt(dut_fields()), fmt(exp_fields()));
        end
        repeat ($urandom_range(8, 3)) begin
            press(1'b0, 1'b1, rand_hold());
            n_checks++;
            if (dut_fields() !== exp_fields()) begin
                n_fail++;
                $display("FAIL min_inc_random: got %s, want %s", fmt(dut_fields()), fmt(exp_fields()));
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
`ifdef CLOCK_SET_BLINK_EN
        int   last_chg;
        int   n_chg;
        logic prev_b;
`endif
        n = (17 - (m_time / 60) % 60 + 60) % 60;
        repeat (n) press(1'b0, 1'b1, rand_hold());
        n_checks++;
        if (bus.minutes !== 6'd17 || bus.set_mode !== 2'b10) begin
            n_fail++;
            $display("FAIL set_min17: got %s, want minutes=17 mode=2", fmt(dut_fields()));
        end
`ifdef CLOCK_SET_BLINK_EN
        last_chg = -1;
        n_chg    = 0;
        prev_b   = bus.blank[1];
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (bus.blank[1] !== prev_b) begin
                if (last_chg >= 0) begin
                    n_checks++;
                    if (i - last_chg != BLINK_DIV) begin
                        n_fail++;
                        $display("FAIL blink_period: toggle after %0d cycles, want %0d", i - last_chg, BLINK_DIV);
                    end
                end
                last_chg = i;
                n_chg++;
                prev_b   = bus.blank[1];
            end
        end
        n_checks++;
        if (n_chg < 3) begin
            n_fail++;
            $display("FAIL blink_toggles: got %0d toggles in 40 cycles, want >= 3", n_chg);
        end
`endif
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({dut_fields(), bus.sec_tick, bus.blank} !== 23'd0) begin
            n_fail++;
            $display("FAIL async_reset: %s tick=%b blank=%b, want all zero", fmt(dut_fields()), bus.sec_tick, bus.blank);
        end
        repeat (2) cyc();
        m_time = 0; m_mode = 0; ticks_used = 0;
        rst_n = 1'b1;
        // INC is ignored while running.
        repeat (2) begin
            press(1'b0, 1'b1, rand_hold());
            n_checks++;
            if (dut_fields() !== exp_fields()) begin
                n_fail++;
                $display("FAIL run_inc_ignored: got %s, want %s", fmt(dut_fields()), fmt(exp_fields()));
            end
        end
    endtask

    initial begin
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        test_reset();
        test_free_run();
        test_set_rollover();
        test_hour_wrap();
        test_simultaneous();
        test_glitch();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
